// File: rtl/video_frame_writer_pkg.sv
// Shared video-stream definitions for the frame writer: pixel coordinate
// widths and the frame-coordinate record carried alongside each pixel on
// the video daisy chain.
package video_frame_writer_pkg;

    localparam int H_SIZE  = 10;
    localparam int V_SIZE  = 10;
    localparam int AVM_DW  = 16;

    typedef struct packed {
        logic [H_SIZE-1:0] hc;
        logic [V_SIZE-1:0] vc;
        logic              frame_start;
    } vga_fc_t;

endpackage

// File: rtl/video_frame_writer.sv
// Memory-side consumer of the video stream. Each visible pixel is written
// to frame-buffer word vc*H_DISPLAY+hc through an Avalon-MM style master.
// The write request registers are the only pixel storage: a new pixel is
// only accepted when the pending write is absent or completing this cycle.
module video_frame_writer
    import video_frame_writer_pkg::*;
#(
    parameter int RGB_SIZE  = 12,
    parameter int H_DISPLAY = 640,
    parameter int V_DISPLAY = 480,
    parameter int AW        = 19
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                snk_vld,
    output logic                snk_rdy,
    input  vga_fc_t             snk_fc,
    input  logic [RGB_SIZE-1:0] snk_rgb,
    input  logic                ctrl_enable,
    output logic [AW-1:0]       avm_address,
    output logic                avm_write,
    output logic [AVM_DW-1:0]   avm_writedata,
    input  logic                avm_waitrequest,
    output logic                frame_done,
    output logic                busy
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SYNC,
        ST_WRITE
    } state_t;

    state_t      r_state;
    logic        r_last;

    logic        w_accept;
    logic        w_visible;
    logic        w_isLast;
    logic        w_done;
    logic        w_frameDone;
    logic        w_stop;
    logic        w_load;
    logic [31:0] w_addrFull;

    // A write finishes when the request is up and memory is not stalling.
    assign w_done      = avm_write && !avm_waitrequest;
    assign w_frameDone = w_done && r_last;
    assign w_stop      = w_frameDone && !ctrl_enable;

    // Outside WRITE every pixel is taken and dropped; in WRITE a pixel is
    // only taken when the output register is free or draining this cycle.
    assign snk_rdy  = (r_state == ST_WRITE) ? (!avm_write || !avm_waitrequest) : 1'b1;
    assign w_accept = snk_vld && snk_rdy;

    assign w_visible  = (32'(snk_fc.hc) < 32'(H_DISPLAY)) && (32'(snk_fc.vc) < 32'(V_DISPLAY));
    assign w_isLast   = (32'(snk_fc.hc) == 32'(H_DISPLAY - 1)) && (32'(snk_fc.vc) == 32'(V_DISPLAY - 1));
    assign w_addrFull = 32'(snk_fc.vc) * 32'(H_DISPLAY) + 32'(snk_fc.hc);

    // SYNC starts writing at the frame_start pixel; in WRITE every visible
    // pixel is written except one arriving as a disabled frame finishes.
    assign w_load = w_accept && w_visible &&
                    (((r_state == ST_SYNC) && ctrl_enable && snk_fc.frame_start) ||
                     ((r_state == ST_WRITE) && !w_stop));

    assign frame_done = w_frameDone;
    assign busy       = (r_state != ST_IDLE) || avm_write;

    // Capture FSM plus the write-request output register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_last        <= 1'b0;
            avm_write     <= 1'b0;
            avm_address   <= '0;
            avm_writedata <= '0;
        end else begin
            if (w_load) begin
                avm_write     <= 1'b1;
                avm_address   <= w_addrFull[AW-1:0];
                avm_writedata <= AVM_DW'(snk_rgb);
                r_last        <= w_isLast;
            end else if (w_done) begin
                avm_write <= 1'b0;
                r_last    <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (ctrl_enable) begin
                        r_state <= ST_SYNC;
                    end
                end
                ST_SYNC: begin
                    if (!ctrl_enable) begin
                        r_state <= ST_IDLE;
                    end else if (w_accept && snk_fc.frame_start) begin
                        r_state <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (w_stop) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_video_frame_writer.sv
// Self-checking bench for video_frame_writer using a reduced frame size.
// The driver models which pixels should be written and queues the expected
// memory writes; a monitor pops them as the DUT completes each write.
module tb_video_frame_writer;
    import video_frame_writer_pkg::*;

    localparam int RGB = 12;
    localparam int H   = 32;
    localparam int V   = 12;
    localparam int AWB = 9;

    localparam int M_IDLE  = 0;
    localparam int M_SYNC  = 1;
    localparam int M_WRITE = 2;

    typedef struct packed {
        logic [AWB-1:0] addr;
        logic [15:0]    data;
        logic           last;
    } sbEntry_t;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           snk_vld = 1'b0;
    logic           snk_rdy;
    vga_fc_t        snk_fc = '0;
    logic [RGB-1:0] snk_rgb = '0;
    logic           ctrl_enable = 1'b0;
    logic [AWB-1:0] avm_address;
    logic           avm_write;
    logic [15:0]    avm_writedata;
    logic           avm_waitrequest = 1'b0;
    logic           frame_done;
    logic           busy;

    sbEntry_t sbq[$];
    int       testsRun    = 0;
    int       testsFailed = 0;
    int       writeCount  = 0;
    int       doneCount   = 0;
    int       modelMode   = M_IDLE;
    bit       randWait    = 1'b0;

    video_frame_writer #(
        .RGB_SIZE (RGB),
        .H_DISPLAY(H),
        .V_DISPLAY(V),
        .AW       (AWB)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .snk_vld        (snk_vld),
        .snk_rdy        (snk_rdy),
        .snk_fc         (snk_fc),
        .snk_rgb        (snk_rgb),
        .ctrl_enable    (ctrl_enable),
        .avm_address    (avm_address),
        .avm_write      (avm_write),
        .avm_writedata  (avm_writedata),
        .avm_waitrequest(avm_waitrequest),
        .frame_done     (frame_done),
        .busy           (busy)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    // Counts every comparison and reports any that disagree.
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    // Reference behaviour for an accepted pixel: tracks whether capture is
    // active and queues the memory write the DUT owes for it.
    task automatic modelAccept(input int hc, input int vc, input bit fs, input logic [RGB-1:0] rgb);
        sbEntry_t e;
        bit visible;
        visible = (hc < H) && (vc < V);
        if (modelMode == M_SYNC && fs && ctrl_enable) modelMode = M_WRITE;
        if (modelMode == M_WRITE && visible) begin
            e.addr = AWB'(vc * H + hc);
            e.data = 16'(rgb);
            e.last = (hc == H - 1) && (vc == V - 1);
            sbq.push_back(e);
            if (e.last && !ctrl_enable) modelMode = M_IDLE;
        end
    endtask

    // Presents one pixel and holds it until the DUT takes it.
    task automatic applyStimulus(input int hc, input int vc, input bit fs);
        logic [RGB-1:0] rgb;
        bit accepted;
        int budget;
        rgb = RGB'($urandom);
        accepted = 1'b0;
        budget = 0;
        snk_vld = 1'b1;
        snk_fc.hc = H_SIZE'(hc);
        snk_fc.vc = V_SIZE'(vc);
        snk_fc.frame_start = fs;
        snk_rgb = rgb;
        while (!accepted && budget < 50) begin
            @(negedge clk);
            accepted = snk_rdy;
            @(posedge clk);
            #1;
            budget++;
        end
        snk_vld = 1'b0;
        checkOutput("handshake", 32'(accepted), 32'd1);
        if (accepted) modelAccept(hc, vc, fs, rgb);
    endtask

    // Writes pixel hc of line 0, then stalls memory for three cycles while
    // the next pixel waits, checking the request is held and the sink is blocked.
    task automatic stallPixel(input int hc);
        applyStimulus(hc, 0, 1'b0);
        avm_waitrequest = 1'b1;
        snk_vld = 1'b1;
        snk_fc.hc = H_SIZE'(hc + 1);
        snk_fc.vc = '0;
        snk_fc.frame_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("stall_write", 32'(avm_write), 32'd1);
            checkOutput("stall_addr", 32'(avm_address), 32'(hc));
            checkOutput("stall_data", 32'(avm_writedata), 32'(sbq[0].data));
            checkOutput("stall_rdy", 32'(snk_rdy), 32'd0);
            @(posedge clk);
            #1;
        end
        avm_waitrequest = 1'b0;
        snk_vld = 1'b0;
    endtask

    // Streams a whole frame with two blanking pixels per line, one blanking
    // line, and an off-screen pixel on line 10.
    task automatic sendFrame(input int dropAtVc, input int stallHc);
        for (int vc = 0; vc <= V; vc++) begin
            if (vc == dropAtVc) ctrl_enable = 1'b0;
            for (int hc = 0; hc < H + 2; hc++) begin
                if (vc == 0 && hc == stallHc) stallPixel(hc);
                else applyStimulus(hc, vc, (hc == 0) && (vc == 0));
            end
            if (vc == 10) applyStimulus(700, 10, 1'b0);
        end
    endtask

    // Optional random memory back-pressure, changed just after each edge.
    always @(posedge clk) begin
        #1;
        if (randWait) avm_waitrequest = ($urandom_range(0, 3) == 0);
    end

    // Scoreboard monitor: every completed write must match the oldest
    // expected entry, and frame_done must only accompany the last pixel.
    always @(negedge clk) begin
        sbEntry_t e;
        if (!rst) begin
            if (avm_write && !avm_waitrequest) begin
                if (sbq.size() == 0) begin
                    checkOutput("sb_underflow", 32'(sbq.size()), 32'd1);
                end else begin
                    e = sbq.pop_front();
                    checkOutput("wr_addr", 32'(avm_address), 32'(e.addr));
                    checkOutput("wr_data", 32'(avm_writedata), 32'(e.data));
                    checkOutput("wr_frame_done", 32'(frame_done), 32'(e.last));
                    writeCount++;
                    if (frame_done) doneCount++;
                end
            end else begin
                checkOutput("frame_done_quiet", 32'(frame_done), 32'd0);
            end
        end
    end

    // Guards against a hung run.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main test sequence.
    initial begin
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_write", 32'(avm_write), 32'd0);
        checkOutput("rst_addr", 32'(avm_address), 32'd0);
        checkOutput("rst_data", 32'(avm_writedata), 32'd0);
        checkOutput("rst_frame_done", 32'(frame_done), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_rdy", 32'(snk_rdy), 32'd1);
        rst = 1'b0;
        @(posedge clk);
        #1;

        applyStimulus(0, 0, 1'b1);
        applyStimulus(1, 0, 1'b0);
        checkOutput("idle_busy", 32'(busy), 32'd0);

        ctrl_enable = 1'b1;
        @(posedge clk);
        #1;
        modelMode = M_SYNC;
        checkOutput("sync_busy", 32'(busy), 32'd1);
        ctrl_enable = 1'b0;
        @(posedge clk);
        #1;
        modelMode = M_IDLE;
        checkOutput("sync_abort_busy", 32'(busy), 32'd0);
        applyStimulus(0, 0, 1'b1);

        ctrl_enable = 1'b1;
        @(posedge clk);
        #1;
        modelMode = M_SYNC;
        for (int hc = 10; hc < 16; hc++) applyStimulus(hc, 5, 1'b0);
        checkOutput("midframe_no_write", 32'(writeCount), 32'd0);
        sendFrame(-1, -1);
        checkOutput("frame1_writes", 32'(writeCount), 32'(H * V));
        checkOutput("frame1_done", 32'(doneCount), 32'd1);

        sendFrame(-1, 5);
        checkOutput("frame2_writes", 32'(writeCount), 32'(2 * H * V));
        checkOutput("frame2_done", 32'(doneCount), 32'd2);

        randWait = 1'b1;
        sendFrame(5, -1);
        randWait = 1'b0;
        @(posedge clk);
        #1;
        avm_waitrequest = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("frame3_writes", 32'(writeCount), 32'(3 * H * V));
        checkOutput("frame3_done", 32'(doneCount), 32'd3);
        checkOutput("stop_rdy", 32'(snk_rdy), 32'd1);
        checkOutput("stop_busy", 32'(busy), 32'd0);
        applyStimulus(0, 0, 1'b1);

        ctrl_enable = 1'b1;
        @(posedge clk);
        #1;
        modelMode = M_SYNC;
        applyStimulus(H - 1, V - 1, 1'b1);
        avm_waitrequest = 1'b1;
        @(negedge clk);
        checkOutput("pre_rst_write", 32'(avm_write), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midrst_write", 32'(avm_write), 32'd0);
        checkOutput("midrst_frame_done", 32'(frame_done), 32'd0);
        checkOutput("midrst_busy", 32'(busy), 32'd0);
        checkOutput("midrst_rdy", 32'(snk_rdy), 32'd1);
        sbq.delete();
        modelMode = M_IDLE;
        ctrl_enable = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        avm_waitrequest = 1'b0;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_no_done", 32'(doneCount), 32'd3);
        checkOutput("sb_empty", 32'(sbq.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
